mem_port_arbiter: RTL and testbench



---
 rtl/mips32_pkg.sv | 18 +
 rtl/arb_rr2.sv | 14 +
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, port indices
// and the grant-vector helper.
package mips32_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick. On a tie the port that was not served last wins.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       pick,
   output logic       valid
);

   always_comb begin
      valid = |req;
      pick  = (req == 2'b11) ? ~last : req[1];
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the MIPS32 core (port 0) and an auxiliary
// master (port 1) with round-robin arbitration and an access watchdog.
//
// state  | meaning
// IDLE   | no owner; arbitrate pending requests
// ACCESS | strobes driven from latched request; wait for mem_ready or timeout
// RESP   | done (and err on timeout) pulse to the owner; update last_gnt
module mem_port_arbiter
   import mips32_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_done,
   output logic          p0_err,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_done,
   output logic          p1_err,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic [1:0]    gnt,
   output logic          busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT);

   arb_state_t    state;
   logic          sel;
   logic          last_gnt;
   logic          we_r;
   logic [CW-1:0] wd_cnt;
   logic          arb_pick;
   logic          arb_valid;

   arb_rr2 u_arb (
      .req   ({p1_req, p0_req}),
      .last  (last_gnt),
      .pick  (arb_pick),
      .valid (arb_valid)
   );

   // Watchdog is a down-counter loaded on grant; terminal count 0 aborts,
   // giving TIMEOUT+1 ACCESS cycles before the error response.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= IDLE;
         sel       <= PORT_CPU;
         last_gnt  <= PORT_AUX;
         we_r      <= 1'b0;
         wd_cnt    <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         gnt       <= 2'b00;
         busy      <= 1'b0;
         p0_done   <= 1'b0;
         p0_err    <= 1'b0;
         p1_done   <= 1'b0;
         p1_err    <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         p0_done <= 1'b0;
         p0_err  <= 1'b0;
         p1_done <= 1'b0;
         p1_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  sel       <= arb_pick;
                  we_r      <= arb_pick ? p1_we : p0_we;
                  mem_read  <= arb_pick ? ~p1_we : ~p0_we;
                  mem_write <= arb_pick ? p1_we : p0_we;
                  mem_addr  <= arb_pick ? p1_addr : p0_addr;
                  mem_wdata <= arb_pick ? p1_wdata : p0_wdata;
                  gnt       <= port_onehot(arb_pick);
                  wd_cnt    <= WD_LOAD;
                  busy      <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_ready || wd_cnt == '0) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= RESP;
                  if (sel == PORT_AUX) begin
                     p1_done <= 1'b1;
                     p1_err  <= ~mem_ready;
                  end else begin
                     p0_done <= 1'b1;
                     p0_err  <= ~mem_ready;
                  end
                  if (mem_ready && !we_r) begin
                     if (sel == PORT_AUX) p1_rdata <= mem_rdata;
                     else                 p0_rdata <= mem_rdata;
                  end
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end
            RESP: begin
               last_gnt <= sel;
               gnt      <= 2'b00;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               gnt       <= 2'b00;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single read, round-robin,
// delayed write, watchdog timeout and reset during an access.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        nrst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [31:0] p0_rdata, p1_rdata;
   logic        p0_done, p0_err, p1_done, p1_err;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [1:0]  gnt;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
      .clk(clk), .nrst(nrst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .gnt(gnt), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({mem_read, mem_write, gnt, busy, p0_done, p1_done, p0_err, p1_err} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got rd=%b wr=%b gnt=%b busy=%b d0=%b d1=%b expected all 0",
                     i, mem_read, mem_write, gnt, busy, p0_done, p1_done);
         end
      end
      checks++;
      if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata got p0=%h p1=%h expected 0", p0_rdata, p1_rdata);
      end
      nrst = 1'b1;
      tick();
      checks++;
      if (gnt !== 2'b01 || !busy || mem_read !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_grant got gnt=%b busy=%b rd=%b expected 01/1/1", gnt, busy, mem_read);
      end
      mem_ready = 1'b1;
      tick();
      p0_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0040;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h40 || gnt !== 2'b01 || p0_done !== 1'b0) begin
         failures++;
         $display("FAIL read_access got rd=%b wr=%b addr=%h gnt=%b done=%b expected 1/0/40/01/0",
                  mem_read, mem_write, mem_addr, gnt, p0_done);
      end
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      checks++;
      if (p0_done !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'hDEADBEEF || mem_read !== 1'b0 || p1_done !== 1'b0) begin
         failures++;
         $display("FAIL read_resp got done=%b err=%b rdata=%h rd=%b expected 1/0/deadbeef/0",
                  p0_done, p0_err, p0_rdata, mem_read);
      end
      p0_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
      tick();
      checks++;
      if (p0_done !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00 || p0_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL read_idle got done=%b busy=%b gnt=%b rdata=%h expected 0/0/00/deadbeef",
                  p0_done, busy, gnt, p0_rdata);
      end
   endtask

   task automatic test_round_robin();
      logic        exp_port;
      logic [31:0] exp_addr, exp_data;
      nrst = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h200;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h300;
      mem_ready = 1'b1;
      tick();
      nrst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_port = k[0];
         exp_addr = exp_port ? 32'h300 : 32'h200;
         exp_data = 32'hA000_0000 + 32'(k);
         mem_rdata = exp_data;
         tick();
         checks++;
         if (gnt !== (exp_port ? 2'b10 : 2'b01) || mem_addr !== exp_addr || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL rr_grant k=%0d got gnt=%b addr=%h rd=%b expected port %0d addr=%h",
                     k, gnt, mem_addr, mem_read, exp_port, exp_addr);
         end
         tick();
         checks++;
         if ((exp_port ? {p1_done, p0_done} : {p0_done, p1_done}) !== 2'b10 || gnt === 2'b11 ||
             (exp_port ? p1_rdata : p0_rdata) !== exp_data) begin
            failures++;
            $display("FAIL rr_done k=%0d got d0=%b d1=%b gnt=%b r0=%h r1=%h expected port %0d data=%h",
                     k, p0_done, p1_done, gnt, p0_rdata, p1_rdata, exp_port, exp_data);
         end
         tick();
         checks++;
         if (gnt !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle k=%0d got gnt=%b busy=%b expected 00/0", k, gnt, busy);
         end
      end
      p0_req = 1'b0; p1_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_write_wait();
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h100; p1_wdata = 32'h1234_5678;
      mem_rdata = 32'hBAD0_BAD0; mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'h1234_5678 ||
             mem_addr !== 32'h100 || gnt !== 2'b10 || p1_done !== 1'b0) begin
            failures++;
            $display("FAIL wr_access cyc=%0d got wr=%b rd=%b wdata=%h addr=%h gnt=%b done=%b expected 1/0/12345678/100/10/0",
                     i, mem_write, mem_read, mem_wdata, mem_addr, gnt, p1_done);
         end
         if (i == 4) mem_ready = 1'b1;
         tick();
      end
      checks++;
      if (p1_done !== 1'b1 || p1_err !== 1'b0 || p1_rdata !== 32'hA000_0005 || mem_write !== 1'b0) begin
         failures++;
         $display("FAIL wr_resp got done=%b err=%b rdata=%h wr=%b expected 1/0/a0000005/0",
                  p1_done, p1_err, p1_rdata, mem_write);
      end
      p1_req = 1'b0; p1_we = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h400;
      mem_ready = 1'b0; mem_rdata = 32'hFFFF_0000;
      tick();
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h500;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (p0_done !== 1'b0 || mem_read !== 1'b1 || gnt !== 2'b01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL to_wait cyc=%0d got done=%b rd=%b gnt=%b busy=%b expected 0/1/01/1",
                     i, p0_done, mem_read, gnt, busy);
         end
         tick();
      end
      checks++;
      if (p0_done !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'hA000_0004 || mem_read !== 1'b0) begin
         failures++;
         $display("FAIL to_resp got done=%b err=%b rdata=%h rd=%b expected 1/1/a0000004/0",
                  p0_done, p0_err, p0_rdata, mem_read);
      end
      p0_req = 1'b0;
      tick();
      checks++;
      if (p0_done !== 1'b0 || p0_err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL to_idle got done=%b err=%b busy=%b expected 0/0/0", p0_done, p0_err, busy);
      end
      tick();
      checks++;
      if (gnt !== 2'b10 || mem_addr !== 32'h500 || mem_read !== 1'b1) begin
         failures++;
         $display("FAIL to_next_grant got gnt=%b addr=%h rd=%b expected 10/500/1", gnt, mem_addr, mem_read);
      end
      mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
      tick();
      checks++;
      if (p1_done !== 1'b1 || p1_err !== 1'b0 || p1_rdata !== 32'h5555_AAAA) begin
         failures++;
         $display("FAIL to_next_resp got done=%b err=%b rdata=%h expected 1/0/5555aaaa", p1_done, p1_err, p1_rdata);
      end
      p1_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h600; mem_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (mem_read !== 1'b1 || gnt !== 2'b01) begin
         failures++;
         $display("FAIL rst_mid_access got rd=%b gnt=%b expected 1/01", mem_read, gnt);
      end
      nrst = 1'b0;
      tick();
      checks++;
      if (mem_read !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00 || p0_done !== 1'b0 || p0_rdata !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid_abort got rd=%b busy=%b gnt=%b done=%b rdata=%h expected 0/0/00/0/0",
                  mem_read, busy, gnt, p0_done, p0_rdata);
      end
      nrst = 1'b1;
      tick();
      checks++;
      if (gnt !== 2'b01 || mem_addr !== 32'h600 || mem_read !== 1'b1 || p0_done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_restart got gnt=%b addr=%h rd=%b done=%b expected 01/600/1/0",
                  gnt, mem_addr, mem_read, p0_done);
      end
      mem_ready = 1'b1; mem_rdata = 32'h600D_600D;
      tick();
      checks++;
      if (p0_done !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'h600D_600D) begin
         failures++;
         $display("FAIL rst_mid_resp got done=%b err=%b rdata=%h expected 1/0/600d600d", p0_done, p0_err, p0_rdata);
      end
      p0_req = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_wait();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
